cordic_serial_tx: RTL and testbench

//  Transmitter end of the 2-bit-digit CORDIC stage link. Accepts a parallel {X,Y,A,IS} word

---
 rtl/cordic_pkg.sv | 16 +
 rtl/cordic_serial_tx.sv | 137 +++++++++++++
 tb/tb_cordic_serial_tx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and frame-state type for the 2-bit-digit CORDIC stage link.
package cordic_pkg;

  localparam int unsigned CORDIC_W  = 12;
  localparam int unsigned DIGIT_W   = 2;
  localparam int unsigned NDIG      = 6;
  localparam int unsigned FRAME_LEN = 7;
  localparam int unsigned GUARD_LEN = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DIG
  } tx_st_t;

endpackage

// File: rtl/cordic_serial_tx.sv
// Link transmitter: buffers one parallel {X,Y,A,IS} word, then emits a Rdy pulse
// followed by NDIG digits per word, LSB first, into CORDIC stage 0.
module cordic_serial_tx #(
  parameter int unsigned DATA_W    = cordic_pkg::CORDIC_W,
  parameter int unsigned DIGIT_W   = cordic_pkg::DIGIT_W,
  parameter int unsigned NDIG      = cordic_pkg::NDIG,
  parameter int unsigned GUARD_LEN = cordic_pkg::GUARD_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_x,
  input  logic [DATA_W-1:0]  in_y,
  input  logic [DATA_W-1:0]  in_a,
  input  logic               in_is,
  output logic [DIGIT_W-1:0] Xout,
  output logic [DIGIT_W-1:0] Yout,
  output logic [DIGIT_W-1:0] Aout,
  output logic               ISout,
  output logic               Rdy,
  output logic               busy,
  output logic [7:0]         frm_cnt
);

  import cordic_pkg::*;

  localparam int unsigned GW = $clog2(GUARD_LEN + 1);
  localparam logic [2:0]  LAST_DIG = 3'(NDIG - 1);

  tx_st_t            st_q, st_d;
  logic [2:0]        dig_q, dig_d;
  logic [GW-1:0]     guard_q, guard_d;
  logic              bfull_q, bfull_d;
  logic [DATA_W-1:0] bx_q, bx_d, by_q, by_d, ba_q, ba_d;
  logic              bis_q, bis_d;
  logic [DATA_W-1:0] sx_q, sx_d, sy_q, sy_d, sa_q, sa_d;
  logic              is_q, is_d;
  logic [7:0]        frm_q, frm_d;
  logic              accept;

  assign in_ready = !bfull_q && (guard_q == '0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    st_d    = st_q;
    dig_d   = dig_q;
    guard_d = (guard_q == '0) ? guard_q : guard_q - GW'(1);
    bfull_d = bfull_q;
    bx_d    = bx_q;
    by_d    = by_q;
    ba_d    = ba_q;
    bis_d   = bis_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sa_d    = sa_q;
    is_d    = is_q;
    frm_d   = frm_q;

    if (accept) begin
      bfull_d = 1'b1;
      bx_d    = in_x;
      by_d    = in_y;
      ba_d    = in_a;
      bis_d   = in_is;
    end

    case (st_q)
      // A word accepted while idle starts its frame on the very next cycle.
      IDLE: begin
        if (bfull_q || accept) st_d = START;
      end
      START: begin
        st_d    = DIG;
        dig_d   = '0;
        sx_d    = bx_q;
        sy_d    = by_q;
        sa_d    = ba_q;
        is_d    = bis_q;
        bfull_d = 1'b0;
        frm_d   = frm_q + 8'd1;
      end
      DIG: begin
        sx_d = sx_q >> DIGIT_W;
        sy_d = sy_q >> DIGIT_W;
        sa_d = sa_q >> DIGIT_W;
        if (dig_q == LAST_DIG) begin
          st_d = bfull_q ? START : IDLE;
        end else begin
          dig_d = dig_q + 3'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      dig_q   <= '0;
      guard_q <= GW'(GUARD_LEN);
      bfull_q <= 1'b0;
      bx_q    <= '0;
      by_q    <= '0;
      ba_q    <= '0;
      bis_q   <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      sa_q    <= '0;
      is_q    <= 1'b0;
      frm_q   <= '0;
    end else begin
      st_q    <= st_d;
      dig_q   <= dig_d;
      guard_q <= guard_d;
      bfull_q <= bfull_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      ba_q    <= ba_d;
      bis_q   <= bis_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sa_q    <= sa_d;
      is_q    <= is_d;
      frm_q   <= frm_d;
    end
  end

  assign Rdy     = (st_q == START);
  assign Xout    = (st_q == DIG) ? sx_q[DIGIT_W-1:0] : '0;
  assign Yout    = (st_q == DIG) ? sy_q[DIGIT_W-1:0] : '0;
  assign Aout    = (st_q == DIG) ? sa_q[DIGIT_W-1:0] : '0;
  assign ISout   = is_q;
  assign busy    = (st_q != IDLE) || bfull_q;
  assign frm_cnt = frm_q;

endmodule

// File: tb/tb_cordic_serial_tx.sv
// Self-checking bench for cordic_serial_tx: frame-position reference model plus directed literal checks.
module tb_cordic_serial_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_x = '0, in_y = '0, in_a = '0;
  logic        in_is = 1'b0;
  logic [1:0]  Xout, Yout, Aout;
  logic        ISout, Rdy, busy;
  logic [7:0]  frm_cnt;

  cordic_serial_tx #(.DATA_W(12), .DIGIT_W(2), .NDIG(6), .GUARD_LEN(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_a(in_a), .in_is(in_is),
    .Xout(Xout), .Yout(Yout), .Aout(Aout), .ISout(ISout),
    .Rdy(Rdy), .busy(busy), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;
  int unsigned cyc = 0;
  bit          chk_en = 1'b0;
  int unsigned rdy_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a word sits in a one-deep buffer; a frame is positions 0 (Rdy) .. 6 (last digit).
  int          m_guard = 7;
  bit          m_full = 1'b0;
  logic [11:0] mbx = '0, mby = '0, mba = '0;
  bit          mbis = 1'b0;
  int          m_pos = -1;
  logic [11:0] mwx = '0, mwy = '0, mwa = '0;
  bit          m_is = 1'b0;
  logic [7:0]  m_frm = '0;

  function automatic bit m_ready();
    return (m_guard == 0) && !m_full;
  endfunction

  function automatic logic [1:0] digit_of(input logic [11:0] w, input int p);
    logic [11:0] s;
    s = w >> (2 * (p - 1));
    return s[1:0];
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [1:0] ex, ey, ea;
    bit in_win;
    in_win = (m_pos >= 1) && (m_pos <= 6);
    ex = in_win ? digit_of(mwx, m_pos) : 2'b00;
    ey = in_win ? digit_of(mwy, m_pos) : 2'b00;
    ea = in_win ? digit_of(mwa, m_pos) : 2'b00;
    return {m_pos == 0, ex, ey, ea, m_is, (m_pos >= 0) || m_full, m_ready(), m_frm};
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    int np;
    if (rst) begin
      m_guard = 7; m_full = 1'b0; m_pos = -1; m_is = 1'b0; m_frm = '0;
      mwx = '0; mwy = '0; mwa = '0;
    end else begin
      acc = in_valid && m_ready();
      np  = m_pos;
      if (m_pos == -1) begin
        if (m_full || acc) np = 0;
      end else if (m_pos == 0) begin
        np = 1; mwx = mbx; mwy = mby; mwa = mba; m_is = mbis; m_full = 1'b0; m_frm = m_frm + 8'd1;
      end else if (m_pos < 6) begin
        np = m_pos + 1;
      end else begin
        np = m_full ? 0 : -1;
      end
      if (m_guard > 0) m_guard--;
      if (acc) begin
        m_full = 1'b1; mbx = in_x; mby = in_y; mba = in_a; mbis = in_is;
      end
      m_pos = np;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs", {14'b0, Rdy, Xout, Yout, Aout, ISout, busy, in_ready, frm_cnt}, {14'b0, exp_vec()});
      if (Rdy === 1'b1) rdy_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts at a negedge; counts cycles with in_ready low.
  task automatic count_guard(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) break;
      n++;
      tick();
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [11:0] x, input logic [11:0] y, input logic [11:0] a, input logic is);
    bit ok, r;
    in_valid = 1'b1; in_x = x; in_y = y; in_a = a; in_is = is;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Called in the Rdy cycle; collects the six digits of each lane.
  task automatic capture_frame(output bit r, output logic [11:0] xr, output logic [11:0] yr,
                               output logic [11:0] ar, output bit is1);
    @(negedge clk);
    r = Rdy;
    xr = '0; yr = '0; ar = '0; is1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      xr[2*k +: 2] = Xout;
      yr[2*k +: 2] = Yout;
      ar[2*k +: 2] = Aout;
      if (k == 0) is1 = ISout;
    end
  endtask

  initial begin
    int n;
    bit r, is1;
    logic [11:0] xr, yr, ar;
    int unsigned nrdy;

    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit r, is1;
    logic [11:0] xr, yr, ar;
    int unsigned nrdy;

    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    // Word offered throughout the guard window.
    in_valid = 1'b1; in_x = 12'h4DA; in_y = 12'h000; in_a = 12'h1FF; in_is = 1'b1;
    @(negedge clk);
    count_guard(n);
    check("guard_len", 32'(n), 32'd7);
    tick();
    in_valid = 1'b0;
    capture_frame(r, xr, yr, ar, is1);
    check("t1_rdy_latency", {31'b0, r}, 32'd1);
    check("t1_x", {20'b0, xr}, 32'h4DA);
    check("t1_y", {20'b0, yr}, 32'h000);
    check("t1_a", {20'b0, ar}, 32'h1FF);
    check("t1_is", {31'b0, is1}, 32'd1);
    check("t1_frm_cnt", {24'b0, frm_cnt}, 32'd1);

    // Three words back to back.
    repeat (5) tick();
    nrdy = rdy_q.size();
    for (int w = 0; w < 3; w++)
      send_word(12'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
    repeat (25) tick();
    check("t2_frames", rdy_q.size() - nrdy, 32'd3);
    if (rdy_q.size() >= nrdy + 3) begin
      check("t2_period_a", rdy_q[nrdy + 1] - rdy_q[nrdy], 32'd7);
      check("t2_period_b", rdy_q[nrdy + 2] - rdy_q[nrdy + 1], 32'd7);
    end

    // Sign-bit-only angle.
    send_word(12'($urandom), 12'($urandom), 12'h800, 1'b0);
    capture_frame(r, xr, yr, ar, is1);
    check("t3_rdy", {31'b0, r}, 32'd1);
    check("t3_a", {20'b0, ar}, 32'h800);
    check("t3_is", {31'b0, is1}, 32'd0);

    // Reset in the middle of a frame with a second word buffered.
    repeat (5) tick();
    send_word(12'h123, 12'h456, 12'h789, 1'b1);
    send_word(12'hABC, 12'hDEF, 12'h135, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nrdy = rdy_q.size();
    @(negedge clk);
    check("t5_after_rst", {25'b0, Rdy, Xout, Yout, Aout}, 32'd0);
    count_guard(n);
    check("t5_guard_len", 32'(n), 32'd7);
    repeat (15) tick();
    check("t5_no_frame", rdy_q.size() - nrdy, 32'd0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      tick();
      rst      = ($urandom_range(0, 149) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_x = 12'($urandom); in_y = 12'($urandom); in_a = 12'($urandom); in_is = 1'($urandom);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
